// File: rtl/fp_addsub_param.sv
// Multi-cycle parametrised IEEE-754 style adder/subtractor with a start/done handshake.
// One FSM state per datapath step; special operands bypass the arithmetic so latency is fixed.
module fp_addsub_param #(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23,
  parameter int ROUND_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 op_sub,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 invalid,
  output logic                 inexact
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;   // hidden bit + fraction + guard/round/sticky
  localparam int EW = EXP_W + 1;   // one bit of headroom for exponent increments
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]     a_lat, b_lat;
  logic             sub_lat;
  logic             sa_u, sb_u, byp_u, inv_u;
  logic [EXP_W-1:0] ea_u, eb_u;
  logic [MAN_W:0]   ma_u, mb_u;
  logic [W-1:0]     spec_u;
  logic             sign_l, sub_l;
  logic [EW-1:0]    e_l, e_d, e_n, e_r;
  logic [SW-1:0]    ml_l, ms_l, m_n;
  logic [SW:0]      sum_d;
  logic             sign_d, sign_n, sign_r, inx_r;
  logic [MAN_W-1:0] frac_r;

  logic [EXP_W-1:0] exp_a, exp_b, ea_c, eb_c, big_e, small_e, diff;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic [MAN_W:0]   ma_c, mb_c, big_m, small_m;
  logic             sign_a, sign_b, nan_a, nan_b, inf_a, inf_b, byp_c, inv_c, swap, lost;
  logic [W-1:0]     spec_c, res_c;
  logic [31:0]      sh, lz, lim, shl;
  logic [SW-1:0]    ext, ms_c, m_c;
  logic [SW:0]      sum_c;
  logic             sign_c, g, r, s, inc, ov_c, un_c, iv_c, ix_c;
  logic [EW-1:0]    e_c, er_c;
  logic [MAN_W:0]   mant;
  logic [MAN_W+1:0] rnd;
  logic [MAN_W-1:0] frac_c;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = start ? S_UNPACK : S_IDLE;
      S_UNPACK: state_nx = S_ALIGN;
      S_ALIGN:  state_nx = S_ADD;
      S_ADD:    state_nx = S_NORM;
      S_NORM:   state_nx = S_ROUND;
      S_ROUND:  state_nx = S_PACK;
      S_PACK:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    sign_a = a_lat[W-1];
    sign_b = b_lat[W-1] ^ sub_lat;
    exp_a  = a_lat[MAN_W +: EXP_W];
    exp_b  = b_lat[MAN_W +: EXP_W];
    frac_a = a_lat[MAN_W-1:0];
    frac_b = b_lat[MAN_W-1:0];
    nan_a  = (exp_a == EXP_ONES) && (frac_a != '0);
    nan_b  = (exp_b == EXP_ONES) && (frac_b != '0);
    inf_a  = (exp_a == EXP_ONES) && (frac_a == '0);
    inf_b  = (exp_b == EXP_ONES) && (frac_b == '0);
    // subnormals use effective exponent 1 with a clear hidden bit
    ea_c   = (exp_a == '0) ? EXP_W'(1) : exp_a;
    eb_c   = (exp_b == '0) ? EXP_W'(1) : exp_b;
    ma_c   = {exp_a != '0, frac_a};
    mb_c   = {exp_b != '0, frac_b};
    byp_c  = (exp_a == EXP_ONES) || (exp_b == EXP_ONES);
    inv_c  = 1'b0;
    if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b))) begin
      spec_c = QNAN;
      inv_c  = 1'b1;
    end else if (inf_a) begin
      spec_c = {sign_a, EXP_ONES, {MAN_W{1'b0}}};
    end else begin
      spec_c = {sign_b, EXP_ONES, {MAN_W{1'b0}}};
    end
  end

  always_comb begin
    swap    = {eb_u, mb_u} > {ea_u, ma_u};
    big_e   = swap ? eb_u : ea_u;
    small_e = swap ? ea_u : eb_u;
    big_m   = swap ? mb_u : ma_u;
    small_m = swap ? ma_u : mb_u;
    diff    = big_e - small_e;
    sh      = (32'(diff) > 32'(MAN_W + 3)) ? 32'(MAN_W + 3) : 32'(diff);
    ext     = {small_m, 3'b000};
    lost    = |(ext << (32'(SW) - sh));
    ms_c    = (ext >> sh) | {{(SW-1){1'b0}}, lost};
  end

  always_comb begin
    if (sub_l) sum_c = {1'b0, ml_l} - {1'b0, ms_l};
    else       sum_c = {1'b0, ml_l} + {1'b0, ms_l};
    // an exact-zero difference is +0; matching-sign zeros keep their sign
    sign_c = (sub_l && (sum_c == '0)) ? 1'b0 : sign_l;
  end

  always_comb begin
    lz = 32'(SW);
    for (int i = 0; i < SW; i++) begin
      if (sum_d[i]) lz = 32'(SW - 1 - i);
    end
    lim = 32'(e_d) - 32'd1;
    shl = (lz < lim) ? lz : lim;
    if (sum_d[SW]) begin
      m_c = {sum_d[SW:2], sum_d[1] | sum_d[0]};
      e_c = e_d + EW'(1);
    end else begin
      m_c = sum_d[SW-1:0] << shl;
      e_c = m_c[SW-1] ? (e_d - EW'(shl)) : '0;
    end
  end

  always_comb begin
    mant = m_n[SW-1:3];
    g    = m_n[2];
    r    = m_n[1];
    s    = m_n[0];
    inc  = (ROUND_EN != 0) && g && (r || s || mant[0]);
    rnd  = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
    if (rnd[MAN_W+1]) begin
      frac_c = rnd[MAN_W:1];
      er_c   = e_n + EW'(1);
    end else if ((e_n == '0) && rnd[MAN_W]) begin
      frac_c = rnd[MAN_W-1:0];
      er_c   = EW'(1);
    end else begin
      frac_c = rnd[MAN_W-1:0];
      er_c   = e_n;
    end
  end

  always_comb begin
    ov_c = 1'b0;
    un_c = 1'b0;
    iv_c = 1'b0;
    ix_c = 1'b0;
    if (byp_u) begin
      res_c = spec_u;
      iv_c  = inv_u;
    end else if (e_r >= {1'b0, EXP_ONES}) begin
      res_c = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
      ov_c  = 1'b1;
      ix_c  = 1'b1;
    end else begin
      res_c = {sign_r, e_r[EXP_W-1:0], frac_r};
      ix_c  = inx_r;
      un_c  = (e_r == '0) && inx_r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0; done <= 1'b0; result <= '0;
      overflow <= 1'b0; underflow <= 1'b0; invalid <= 1'b0; inexact <= 1'b0;
      a_lat <= '0; b_lat <= '0; sub_lat <= 1'b0;
      sa_u <= 1'b0; sb_u <= 1'b0; byp_u <= 1'b0; inv_u <= 1'b0;
      ea_u <= '0; eb_u <= '0; ma_u <= '0; mb_u <= '0; spec_u <= '0;
      sign_l <= 1'b0; sub_l <= 1'b0; e_l <= '0; ml_l <= '0; ms_l <= '0;
      sum_d <= '0; sign_d <= 1'b0; e_d <= '0;
      m_n <= '0; e_n <= '0; sign_n <= 1'b0;
      frac_r <= '0; e_r <= '0; sign_r <= 1'b0; inx_r <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_lat <= a; b_lat <= b; sub_lat <= op_sub; busy <= 1'b1;
            overflow <= 1'b0; underflow <= 1'b0; invalid <= 1'b0; inexact <= 1'b0;
          end
        end
        S_UNPACK: begin
          sa_u <= sign_a; sb_u <= sign_b; ea_u <= ea_c; eb_u <= eb_c;
          ma_u <= ma_c; mb_u <= mb_c; byp_u <= byp_c; inv_u <= inv_c; spec_u <= spec_c;
        end
        S_ALIGN: begin
          sign_l <= swap ? sb_u : sa_u;
          sub_l  <= sa_u ^ sb_u;
          e_l    <= {1'b0, big_e};
          ml_l   <= {big_m, 3'b000};
          ms_l   <= ms_c;
        end
        S_ADD:   begin sum_d <= sum_c; sign_d <= sign_c; e_d <= e_l; end
        S_NORM:  begin m_n <= m_c; e_n <= e_c; sign_n <= sign_d; end
        S_ROUND: begin frac_r <= frac_c; e_r <= er_c; sign_r <= sign_n; inx_r <= g | r | s; end
        S_PACK: begin
          result <= res_c; overflow <= ov_c; underflow <= un_c;
          invalid <= iv_c; inexact <= ix_c; done <= 1'b1; busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_param.sv
// Bench for fp_addsub_param: single precision (RNE and truncating) plus a half-precision instance,
// checked against an exact real-arithmetic reference rounded by integer arithmetic.
module tb_fp_addsub_param;
  logic clk = 1'b0;
  logic rst, start, op_sub;
  logic [31:0] a, b, r0, r1;
  logic [15:0] ha, hb, r2;
  logic busy0, busy1, busy2, done0, done1, done2;
  logic ov0, un0, iv0, ix0, ov1, un1, iv1, ix1, ov2, un2, iv2, ix2;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_addsub_param dut0 (.clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy0), .done(done0), .result(r0), .overflow(ov0), .underflow(un0), .invalid(iv0), .inexact(ix0));
  fp_addsub_param #(.ROUND_EN(0)) dut1 (.clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy1), .done(done1), .result(r1), .overflow(ov1), .underflow(un1), .invalid(iv1), .inexact(ix1));
  fp_addsub_param #(.EXP_W(5), .MAN_W(10)) dut2 (.clk(clk), .rst(rst), .start(start), .op_sub(op_sub),
    .a(ha), .b(hb), .busy(busy2), .done(done2), .result(r2), .overflow(ov2), .underflow(un2),
    .invalid(iv2), .inexact(ix2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic real pow2(input int e);
    real p;
    p = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) p = p * 2.0;
    else        for (int i = 0; i < -e; i++) p = p / 2.0;
    return p;
  endfunction

  function automatic real to_real(input int ew, input int mw, input logic [63:0] x);
    longint unsigned one, fr, ex;
    int bias;
    real v;
    one  = 64'd1;
    fr   = x & ((one << mw) - 1);
    ex   = (x >> mw) & ((one << ew) - 1);
    bias = (1 << (ew - 1)) - 1;
    if (ex == 0) v = real'(fr) * pow2(1 - bias - mw);
    else         v = real'(fr + (one << mw)) * pow2(int'(ex) - bias - mw);
    if (x[ew+mw]) v = -v;
    return v;
  endfunction

  // exact sum in double, then rounded to the target format; flags = {ov, un, iv, ix}
  function automatic void model(input int ew, input int mw, input bit rnd, input logic [63:0] x,
      input logic [63:0] y, input bit sub, output logic [63:0] res, output logic [3:0] fl);
    longint unsigned one, emask, ex, ey, fx, fy, sig, q, rem, half;
    int bias, e2, qexp, sh, ef;
    bit sx, sy, s, ix;
    real rr;
    logic [63:0] bits;
    one = 64'd1; emask = (one << ew) - 1;
    ex = (x >> mw) & emask; ey = (y >> mw) & emask;
    fx = x & ((one << mw) - 1); fy = y & ((one << mw) - 1);
    sx = x[ew+mw]; sy = y[ew+mw] ^ sub;
    bias = (1 << (ew - 1)) - 1;
    res = '0; fl = '0;
    if (ex == emask || ey == emask) begin
      if ((ex == emask && fx != 0) || (ey == emask && fy != 0) || (ex == emask && ey == emask && sx != sy)) begin
        res = (emask << mw) | (one << (mw - 1));
        fl  = 4'b0010;
      end else if (ex == emask) res = (64'(sx) << (ew + mw)) | (emask << mw);
      else                      res = (64'(sy) << (ew + mw)) | (emask << mw);
      return;
    end
    rr = sub ? to_real(ew, mw, x) - to_real(ew, mw, y) : to_real(ew, mw, x) + to_real(ew, mw, y);
    bits = $realtobits(rr);
    s = bits[63];
    if (rr == 0.0) begin
      res = 64'(s) << (ew + mw);
      return;
    end
    e2   = int'(bits[62:52]) - 1023;
    sig  = {12'd1, bits[51:0]};
    qexp = ((e2 > 1 - bias) ? e2 : 1 - bias) - mw;
    sh   = qexp - (e2 - 52);
    q    = sig >> sh;
    rem  = sig & ((one << sh) - 1);
    half = one << (sh - 1);
    ix   = (rem != 0);
    if (rnd && (rem > half || (rem == half && q[0]))) q++;
    if (q == (one << (mw + 1))) begin q = q >> 1; qexp++; end
    if (q >= (one << mw)) begin ef = qexp + mw + bias; q = q - (one << mw); end
    else ef = 0;
    if (ef >= int'(emask)) begin
      res = (64'(s) << (ew + mw)) | (emask << mw);
      fl  = 4'b1001;
    end else begin
      res = (64'(s) << (ew + mw)) | (64'(ef) << mw) | q;
      fl  = {1'b0, (ef == 0) && ix, 1'b0, ix};
    end
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (done0) break;
    end
  endtask

  task automatic check_model(input string tag);
    logic [63:0] er;
    logic [3:0] ef;
    model(8, 23, 1'b1, {32'h0, a}, {32'h0, b}, op_sub, er, ef);
    chk({tag, ".rne"}, {r0, ov0, un0, iv0, ix0}, {er[31:0], ef});
    model(8, 23, 1'b0, {32'h0, a}, {32'h0, b}, op_sub, er, ef);
    chk({tag, ".trunc"}, {r1, ov1, un1, iv1, ix1}, {er[31:0], ef});
    model(5, 10, 1'b1, {48'h0, ha}, {48'h0, hb}, op_sub, er, ef);
    chk({tag, ".half"}, {r2, ov2, un2, iv2, ix2}, {er[15:0], ef});
  endtask

  task automatic run(input logic [31:0] ia, input logic [31:0] ib, input logic [15:0] iha,
      input logic [15:0] ihb, input bit sub, input string tag);
    int n;
    @(negedge clk);
    a = ia; b = ib; ha = iha; hb = ihb; op_sub = sub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy"}, 64'(busy0), 64'd1);
    wait_done(n);
    chk({tag, ".latency"}, 64'(n), 64'd6);
    chk({tag, ".busy_at_done"}, 64'(busy0), 64'd0);
    check_model(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pulses;
    logic [31:0] got, ra, rb, fa, fb;
    logic [63:0] er;
    logic [3:0] ef;
    int ea, eb;
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0; ha = '0; hb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {busy0, done0, r0, ov0, un0, iv0, ix0, busy2, done2, r2}, 64'd0);
    rst = 1'b0;

    run(32'h3FC00000, 32'h40100000, 16'h3C00, 16'h3C00, 1'b0, "t1");
    chk("t1.res", {r0, ov0, un0, iv0, ix0}, {32'h40700000, 4'b0000});
    chk("t5.half_one", 64'(r2), 64'h4000);
    run(32'h3F800001, 32'h3F800000, 16'h0001, 16'h0001, 1'b1, "t2a");
    chk("t2a.res", {r0, ov0, un0, iv0, ix0}, {32'h34000000, 4'b0000});
    run(32'h40400000, 32'h40400000, 16'h0001, 16'h0001, 1'b0, "t5h");
    chk("t5.half_sub", {r2, ov2, un2, iv2, ix2}, {16'h0002, 4'b0000});
    run(32'h40400000, 32'h40400000, 16'h0000, 16'h0000, 1'b1, "t2b");
    chk("t2b.zero", {r0, ov0, un0, iv0, ix0}, {32'h00000000, 4'b0000});
    run(32'h3F800000, 32'h33800000, 16'h0000, 16'h0000, 1'b0, "t3a");
    chk("t3a.tie_even", {r0, ix0}, {32'h3F800000, 1'b1});
    chk("t3a.trunc", 64'(r1), 64'h3F800000);
    run(32'h3F800000, 32'h33800001, 16'h0000, 16'h0000, 1'b0, "t3b");
    chk("t3b.above_tie", {r0, ix0}, {32'h3F800001, 1'b1});
    chk("t3b.trunc", 64'(r1), 64'h3F800000);
    run(32'h7F7FFFFF, 32'h7F7FFFFF, 16'h7BFF, 16'h7BFF, 1'b0, "t4a");
    chk("t4a.ovf", {r0, ov0, un0, iv0, ix0}, {32'h7F800000, 4'b1001});
    run(32'h7F800000, 32'h7F800000, 16'h7C00, 16'h7C00, 1'b1, "t4b");
    chk("t4b.inf_inf", {r0, ov0, un0, iv0, ix0}, {32'h7FC00000, 4'b0010});
    run(32'h7FC00001, 32'h12345678, 16'h7E01, 16'h3C00, 1'b0, "t4c");
    chk("t4c.nan", {r0, ov0, un0, iv0, ix0}, {32'h7FC00000, 4'b0010});
    run(32'h00800000, 32'h80400000, 16'h0000, 16'h0000, 1'b0, "t5a");
    chk("t5a.subnormal", {r0, ov0, un0, iv0, ix0}, {32'h00400000, 4'b0000});
    run(32'h80000000, 32'h80000000, 16'h8000, 16'h0000, 1'b0, "negzero");
    chk("negzero.res", 64'(r0), 64'h80000000);

    for (int i = 0; i < 120; i++) begin
      ea = int'($urandom_range(254, 0));
      eb = ea + int'($urandom_range(56, 0)) - 28;
      if (eb < 0) eb = 0;
      if (eb > 254) eb = 254;
      fa = $urandom; fb = $urandom;
      ra = {fa[31], 8'(ea), fa[22:0]};
      rb = {fb[31], 8'(eb), fb[22:0]};
      fa = $urandom;
      run(ra, rb, fa[15:0], fa[31:16], fb[30], "rand");
    end

    // start held while busy: one done, operands from the accepted request
    @(negedge clk);
    a = 32'h3FC00000; b = 32'h40100000; op_sub = 1'b0; start = 1'b1;
    model(8, 23, 1'b1, {32'h0, a}, {32'h0, b}, 1'b0, er, ef);
    @(posedge clk); #1;
    pulses = 0; got = '0;
    for (int k = 0; k < 14; k++) begin
      if (k < 4) begin a = $urandom; b = $urandom; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
      if (done0) begin pulses++; got = r0; end
    end
    chk("held.pulses", 64'(pulses), 64'd1);
    chk("held.res", 64'(got), {32'h0, er[31:0]});

    // back-to-back: start raised in the done cycle
    run(32'h3F800001, 32'h3F800000, 16'h0000, 16'h0000, 1'b1, "b2b1");
    a = 32'h40400000; b = 32'h3F800000; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    chk("b2b.latency", 64'(n), 64'd6);
    chk("b2b.res", 64'(r0), 64'h40800000);

    // reset during ALIGN aborts the operation
    @(negedge clk);
    a = 32'h3FC00000; b = 32'h40100000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.state", {busy0, done0, r0, ov0, un0, iv0, ix0}, 64'd0);
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done0) pulses++;
    end
    chk("abort.no_done", 64'(pulses), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
